rst_release_seq: RTL and testbench
==================================

// Module: rst_release_seq
// PURPOSE
//  Consumes an asynchronous active-low board/POR reset and distributes it as N ordered reset
//  outputs. Assertion is asynchronous; release is synchronised and staggered, one stage per
//  STAGE_DLY cycles. Adds a soft-reset request/ack handshake. Sits between the reset source
//  and downstream logic (e.g. UART TX/RX, FIFOs, user logic) as that logic's reset-release sequencer.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth on i_rst_n deassertion (>=2)
//  N_STAGES     4   number of sequenced reset outputs (1..16)
//  STAGE_DLY    16  cycles between successive stage releases; also soft-reset hold time (>=1)
//  WDOG_CYC     100 watchdog timeout in cycles (used only with RST_WDOG_EN)
// PORTS
//  i_clk        in   1         single clock domain
//  i_rst_n      in   1         async active-low reset; asserts immediately, deassert synchronised
//  i_soft_req   in   1         soft-reset request, level, sampled only in RUN
//  o_soft_ack   out  1         1-cycle pulse when a soft-reset sequence completes
//  o_rst        out  N_STAGES  active-high resets; bit 0 released first
//  o_rst_done   out  1         high while all stages released (state RUN)
//  i_kick       in   1         watchdog kick (present only with RST_WDOG_EN)
//  o_wdog_trip  out  1         sticky watchdog-trip flag (present only with RST_WDOG_EN)
// BEHAVIOUR
//  - i_rst_n low: async clear -> o_rst = all ones, o_rst_done=0, o_soft_ack=0, sync chain=0,
//    stage index=0, delay counter=0, FSM=HOLD; o_wdog_trip=0. Holds regardless of clock.
//  - Sync chain: shift of 1'b1, SYNC_STAGES flops; output rises on the SYNC_STAGES-th rising
//    edge after i_rst_n goes high. Outputs driven from flops only; no comb path from i_rst_n
//    except the async clear.
//  - FSM: HOLD -> RELEASE when sync output high. RELEASE: counter counts 0..STAGE_DLY-1; on
//    terminal count clear o_rst[idx], idx++, counter=0. After o_rst[N_STAGES-1] clears ->
//    RUN on the following edge; o_rst_done=1 in RUN only.
//  - Net timing: o_rst[k] falls STAGE_DLY*(k+1) edges after sync output rises; o_rst_done rises
//    one edge after o_rst[N_STAGES-1] falls. Released bits never re-assert except via reset/SOFT.
//  - RUN & i_soft_req=1: next edge -> SOFT: o_rst=all ones, o_rst_done=0, counter=0, idx=0.
//    SOFT holds STAGE_DLY cycles then -> RELEASE (normal staggered release). The RUN entry that
//    ends a soft sequence pulses o_soft_ack for exactly 1 cycle, same edge o_rst_done rises.
//  - i_soft_req in HOLD/RELEASE/SOFT ignored (not queued). Req still high on return to RUN
//    starts a new soft sequence on the next edge (level semantics).
//  - Counter width $clog2(STAGE_DLY+1); idx width $clog2(N_STAGES+1); no wrap past terminal.
//  - i_rst_n asserted mid-RELEASE/SOFT: immediate async return to reset state, full resequence.
// CONFIGURATION
//  RST_WDOG_EN defined: ports i_kick, o_wdog_trip exist. In RUN a counter increments each cycle,
//    clears on i_kick=1; reaching WDOG_CYC-1 forces entry to SOFT exactly as a soft request,
//    sets o_wdog_trip=1 (sticky until i_rst_n low). Counter held 0 outside RUN. o_soft_ack
//    still pulses at end of a watchdog-initiated sequence. Kick and soft req on same edge:
//    soft req wins.
//  RST_WDOG_EN undefined: no watchdog logic, ports absent; behaviour otherwise identical.
// TESTING (SYNC_STAGES=2, N_STAGES=4, STAGE_DLY=16, edges counted from i_rst_n rise)
//  1 Power-up: i_rst_n low 10 cycles then high -> o_rst=4'hF; bit0 low @18, bit1 @34, bit2 @50,
//    bit3 @66, o_rst_done=1 @67, o_soft_ack stays 0.
//  2 Mid-sequence reset: i_rst_n low between edges at cycle 40 (o_rst=4'hC) -> o_rst=4'hF
//    before next edge, done=0; on re-release, identical timing to scenario 1.
//  3 Soft reset: in RUN, i_soft_req 1 cycle -> next edge o_rst=4'hF, done=0; held 16 cycles,
//    then bits release 16 apart; o_soft_ack 1-cycle pulse coincident with done rising.
//  4 Ignored request: i_soft_req high at cycle 30, 1 cycle -> timing identical to scenario 1,
//    o_soft_ack never asserts.
//  5 Glitch: i_rst_n low 1 ns mid-cycle while in RUN -> o_rst=4'hF immediately, full resequence.
//  6 RST_WDOG_EN, WDOG_CYC=100: no i_kick in RUN -> SOFT after 100 cycles, o_wdog_trip=1
//    sticky through resequence; kick every 50 cycles -> never trips.

Source files
------------

// File: rtl/rst_release_seq.sv
`default_nettype none
// ============================================================================
// Module      : rst_release_seq
// Description : Asynchronous-assert, synchronous staggered-release reset
//               sequencer with soft-reset handshake. Optional watchdog when
//               RST_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int N_STAGES    = 4,
  parameter int STAGE_DLY   = 16,
  parameter int WDOG_CYC    = 100
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_soft_req,
  output logic                o_soft_ack,
  output logic [N_STAGES-1:0] o_rst,
  output logic                o_rst_done
`ifdef RST_WDOG_EN
  ,
  input  logic                i_kick,
  output logic                o_wdog_trip
`endif
);

  localparam int c_CNT_W = $clog2(STAGE_DLY + 1);
  localparam int c_IDX_W = $clog2(N_STAGES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_TC   = c_CNT_W'(STAGE_DLY - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_DONE = c_IDX_W'(N_STAGES);

  if (SYNC_STAGES < 2 || N_STAGES < 1 || N_STAGES > 16 ||
      STAGE_DLY < 1 || WDOG_CYC < 1) begin : g_param_err
    $error("rst_release_seq: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   r_soft_seq;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [N_STAGES-1:0]    w_clr_mask;
  logic                   w_sync_rel;
  logic                   w_tc;
  logic                   w_wdog_fire;
  logic                   w_soft_go;

  // Only the deasserting edge of i_rst_n is synchronised; assertion is async.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sync_rel = r_sync[SYNC_STAGES-1];
  assign w_tc       = (r_cnt == c_CNT_TC);

  for (genvar g = 0; g < N_STAGES; g++) begin : g_clr_mask
    assign w_clr_mask[g] = (r_idx == c_IDX_W'(g));
  end

`ifdef RST_WDOG_EN
  localparam int c_WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_TC = c_WDOG_W'(WDOG_CYC - 1);

  logic [c_WDOG_W-1:0] r_wdog_cnt;

  // A kick on the terminal cycle still rescues the system.
  assign w_wdog_fire = (r_state == ST_RUN) && !i_kick && (r_wdog_cnt == c_WDOG_TC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog_cnt  <= '0;
      o_wdog_trip <= 1'b0;
    end else begin
      if (r_state != ST_RUN || i_kick || w_soft_go) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
      end
      if (w_wdog_fire) begin
        o_wdog_trip <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_fire = 1'b0;
`endif

  assign w_soft_go = (r_state == ST_RUN) && (i_soft_req || w_wdog_fire);

  // r_cnt is always zero in HOLD, so the HOLD exit edge is the first counted
  // cycle; this places stage k's release STAGE_DLY*(k+1) edges after sync rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_soft_seq <= 1'b0;
      o_rst      <= '1;
      o_rst_done <= 1'b0;
      o_soft_ack <= 1'b0;
    end else begin
      o_soft_ack <= 1'b0;
      case (r_state)
        ST_HOLD, ST_RELEASE: begin
          if (r_idx == c_IDX_DONE) begin
            r_state    <= ST_RUN;
            o_rst_done <= 1'b1;
            o_soft_ack <= r_soft_seq;
            r_soft_seq <= 1'b0;
          end else if (r_state == ST_RELEASE || w_sync_rel) begin
            r_state <= ST_RELEASE;
            if (w_tc) begin
              o_rst <= o_rst & ~w_clr_mask;
              r_idx <= r_idx + c_IDX_W'(1);
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (w_soft_go) begin
            r_state    <= ST_SOFT;
            o_rst      <= '1;
            o_rst_done <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_soft_seq <= 1'b1;
          end
        end
        ST_SOFT: begin
          if (w_tc) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rst_release_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_release_seq
// Description : Scoreboard bench: expected output-change events are queued by
//               the stimulus and matched by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_release_seq;

  localparam int c_N = 4;

  logic           i_clk      = 1'b0;
  logic           i_rst_n    = 1'b1;
  logic           i_soft_req = 1'b0;
  logic           o_soft_ack;
  logic           o_rst_done;
  logic [c_N-1:0] o_rst;
`ifdef RST_WDOG_EN
  logic           i_kick     = 1'b0;
  logic           o_wdog_trip;
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  ev_t exp_q[$];

  rst_release_seq #(
    .SYNC_STAGES(2),
    .N_STAGES   (c_N),
    .STAGE_DLY  (16),
    .WDOG_CYC   (100)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_soft_req (i_soft_req),
    .o_soft_ack (o_soft_ack),
    .o_rst      (o_rst),
    .o_rst_done (o_rst_done)
`ifdef RST_WDOG_EN
    ,
    .i_kick     (i_kick),
    .o_wdog_trip(o_wdog_trip)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r, input logic d, input logic a);
    ev_t e;
    e.cyc = c;
    e.vec = {r, d, a};
    exp_q.push_back(e);
  endtask

  // Release relative to the cycle in which i_rst_n rose.
  task automatic push_release(input int b);
    push(b + 18, 4'hE, 1'b0, 1'b0);
    push(b + 34, 4'hC, 1'b0, 1'b0);
    push(b + 50, 4'h8, 1'b0, 1'b0);
    push(b + 66, 4'h0, 1'b0, 1'b0);
    push(b + 67, 4'h0, 1'b1, 1'b0);
  endtask

  // Soft sequence entered on edge e; retrig means the request is still high.
  task automatic push_soft(input int e, input bit retrig);
    push(e,      4'hF, 1'b0, 1'b0);
    push(e + 32, 4'hE, 1'b0, 1'b0);
    push(e + 48, 4'hC, 1'b0, 1'b0);
    push(e + 64, 4'h8, 1'b0, 1'b0);
    push(e + 80, 4'h0, 1'b0, 1'b0);
    push(e + 81, 4'h0, 1'b1, 1'b1);
    if (!retrig) push(e + 82, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
    end
  endtask

  logic [5:0] prev_vec;
  bit         have_prev = 1'b0;

  always @(negedge i_clk) begin
    logic [5:0] v;
    ev_t        e;
    v = {o_rst, o_rst_done, o_soft_ack};
    if (!have_prev || v !== prev_vec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got={rst,done,ack}=%b", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== v) begin
          n_fail++;
          $display("FAIL output_event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                   cyc, v, e.cyc, e.vec);
        end
      end
    end
    prev_vec  = v;
    have_prev = 1'b1;
  end

  initial begin
    // Power-up
    push(1, 4'hF, 1'b0, 1'b0);
    #1 i_rst_n = 1'b0;
    at_cyc(10); i_rst_n = 1'b1; push_release(10);

    // Single-cycle soft request in RUN
    at_cyc(80);  i_soft_req = 1'b1; push_soft(81, 1'b0);
    at_cyc(81);  i_soft_req = 1'b0;

    // Soft request during RELEASE is ignored
    at_cyc(170); i_rst_n = 1'b0; push(170, 4'hF, 1'b0, 1'b0);
    at_cyc(175); i_rst_n = 1'b1; push_release(175);
    at_cyc(205); i_soft_req = 1'b1;
    at_cyc(206); i_soft_req = 1'b0;

    // Reset asserted mid-release (o_rst = C), then full resequence
    at_cyc(250); i_rst_n = 1'b0; push(250, 4'hF, 1'b0, 1'b0);
    at_cyc(253); i_rst_n = 1'b1;
    push(271, 4'hE, 1'b0, 1'b0);
    push(287, 4'hC, 1'b0, 1'b0);
    at_cyc(293); i_rst_n = 1'b0; push(293, 4'hF, 1'b0, 1'b0);
    at_cyc(295); i_rst_n = 1'b1; push_release(295);

    // 1-unit glitch on i_rst_n while in RUN
    at_cyc(370); i_rst_n = 1'b0; #1; i_rst_n = 1'b1;
    push(370, 4'hF, 1'b0, 1'b0); push_release(370);

    // Held request retriggers once RUN is reached again
    at_cyc(440); i_soft_req = 1'b1; push_soft(441, 1'b1); push_soft(523, 1'b0);
    at_cyc(523); i_soft_req = 1'b0;

`ifdef RST_WDOG_EN
    at_cyc(600); check_bit("wdog_trip_idle", o_wdog_trip, 1'b0);
    push_soft(704, 1'b0);
    at_cyc(710); check_bit("wdog_trip_set", o_wdog_trip, 1'b1);
    for (int k = 820; k <= 970; k += 50) begin
      at_cyc(k);     i_kick = 1'b1;
      at_cyc(k + 1); i_kick = 1'b0;
    end
    at_cyc(1000); check_bit("wdog_trip_sticky", o_wdog_trip, 1'b1);
`else
    at_cyc(615);
`endif

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d required=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d required_end_before=100000", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
